mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and one reset. The reset is synchronous and active-high. The clock port is Clk and the reset port is Rst.
REQ-002 Parameter RD_LAT, default 1, SHALL be the number of MR-asserted cycles before RD is captured; legal range 1..2.
REQ-003 Clk  in  1  rising-edge clock.
REQ-004 Rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 req_unsigned  in  1  load is zero-extended when 1, sign-extended when 0.
REQ-010 req_addr  in  10  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  consumer accepts the response.
REQ-014 rsp_rdata  out  32  load result; 0 for stores and errors.
REQ-015 rsp_err  out  1  misaligned or illegal request.
REQ-016 MR, MW  out  1 each  DataMemory read enable and write enable.
REQ-017 Addr  out  8  DataMemory word index.
REQ-018 WD  out  32  DataMemory write data.
REQ-019 RD  in  32  DataMemory read data.

Function
REQ-020 The FSM SHALL have the states IDLE, READ, WRITE and RESP; only one transaction is outstanding at a time.
REQ-021 req_ready SHALL be 1 only in IDLE with Rst low; a request is accepted on a rising edge where req_valid and req_ready are both 1, and all req_* fields are latched at that edge.
REQ-022 Addr SHALL equal latched req_addr[9:2] in READ and WRITE.
REQ-023 MR SHALL be 1 only in READ and MW SHALL be 1 only in WRITE; MR and MW are never both 1.
REQ-024 A request is misaligned when size = 11, size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 0. A misaligned request SHALL go IDLE -> RESP with rsp_err = 1 and SHALL produce no MR or MW pulse.
REQ-025 Load path: IDLE -> READ for RD_LAT cycles, with RD captured at the edge ending the last READ cycle, then -> RESP.
REQ-026 Load data SHALL be the byte lane at addr[1:0] or the half lane at addr[1], extended to 32 bits per req_unsigned.
REQ-027 Word store path: IDLE -> WRITE for one cycle with WD = req_wdata, then -> RESP.
REQ-028 Byte and half store path: READ for RD_LAT cycles, then WRITE for one cycle with WD = captured RD with the addressed lane replaced by req_wdata low bits, then -> RESP.
REQ-029 RESP SHALL hold rsp_valid = 1 with rsp_rdata and rsp_err stable until rsp_ready = 1, then return to IDLE; the next request is accepted no earlier than the following edge.
REQ-030 With RD_LAT = 1 and acceptance at edge E0: a load or word store SHALL drive rsp_valid from E1, and a sub-word store SHALL drive rsp_valid from E2.
REQ-031 In IDLE and RESP, WD SHALL be 0; Addr is don't-care but SHALL NOT be X.

Reset
REQ-032 While Rst = 1 at a rising edge, the block SHALL enter IDLE and clear rsp_valid, rsp_rdata, rsp_err, MR, MW, Addr and WD to 0; req_ready is 0 while Rst is high.
REQ-033 If Rst is asserted mid-transaction, the transaction SHALL be dropped with no response. If Rst is asserted in READ, the pending RMW write SHALL NOT be issued; MR and MW are 0 from the next cycle.

Structure
REQ-034 Package mem_access_pkg SHALL hold the FSM state enum, the req_size encodings and the width constants (data 32, word index 8, byte address 10).
REQ-035 One combinational sub-module, mem_lane_align, SHALL perform load lane extract/extend and store lane merge.

Verification
REQ-036 Word store then load: store 0xDEADBEEF to addr 0x010, then load word from 0x010 -> MW pulse with Addr = 4 and WD = 0xDEADBEEF; rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-037 Byte RMW: memory word 4 = 0x11223344; store byte 0xAB at addr 0x012 -> MR pulse, then MW pulse with WD = 0x11AB3344; a signed byte load from 0x012 returns 0xFFFFFFAB, and an unsigned byte load returns 0x000000AB.
REQ-038 Misalignment: word load at 0x013 and half store at 0x011 -> rsp_err = 1, rsp_rdata = 0, and no MR or MW pulse.
REQ-039 Back-pressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready stays 0, and no memory activity occurs.
REQ-040 Reset in READ during a half store -> no MW pulse, memory word unchanged, no response, and req_ready = 1 on the cycle after Rst deasserts.
REQ-041 Random mix of 5000 requests against a reference memory model -> all responses match, and MR and MW are never both 1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit.
// Holds the FSM states, request size codes and datapath widths.
package mem_access_pkg;

  localparam int DATA_W  = 32;
  localparam int WIDX_W  = 8;
  localparam int BADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic bad;
    bad = 1'b0;
    unique case (size)
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      SZ_ILL:  bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Load lane extract/extend and store lane merge.
// Purely combinational; shared by the load and RMW store paths.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] rd,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(rd >> {off, 3'b000});
    h = 16'(rd >> {off[1], 4'b0000});
    ld_data = rd;
    st_data = wdata;
    unique case (size)
      SZ_BYTE: begin
        ld_data = uns ? {24'b0, b} : {{24{b[7]}}, b};
        st_data = rd;
        st_data[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld_data = uns ? {16'b0, h} : {{16{h[15]}}, h};
        st_data = rd;
        st_data[{off[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        ld_data = rd;
        st_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit in front of a word-wide DataMemory.
// Sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [BADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  output logic               MR,
  output logic               MW,
  output logic [WIDX_W-1:0]  Addr,
  output logic [DATA_W-1:0]  WD,
  input  logic [DATA_W-1:0]  RD
);

  state_t state, state_n;

  logic               lat_we;
  logic               lat_uns;
  logic [1:0]         lat_size;
  logic [BADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0]  lat_wdata;
  logic [DATA_W-1:0]  rd_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [1:0]         cnt;

  logic               bad;
  logic               rd_last;
  logic [DATA_W-1:0]  align_rd;
  logic [DATA_W-1:0]  ld_data;
  logic [DATA_W-1:0]  st_data;

  assign bad     = misaligned(req_size, req_addr[1:0]);
  assign rd_last = (cnt == 2'(RD_LAT - 1));
  // WRITE merges into the captured word; READ extracts from live RD
  assign align_rd = (state == WRITE) ? rd_q : RD;

  mem_lane_align u_align (
    .size    (lat_size),
    .uns     (lat_uns),
    .off     (lat_addr[1:0]),
    .rd      (align_rd),
    .wdata   (lat_wdata),
    .ld_data (ld_data),
    .st_data (st_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    MR        = 1'b0;
    MW        = 1'b0;
    Addr      = '0;
    WD        = '0;
    unique case (state)
      IDLE: begin
        req_ready = !Rst;
        if (req_valid && !Rst) begin
          if (bad)
            state_n = RESP;
          else if (req_we && req_size == SZ_WORD)
            state_n = WRITE;
          else
            state_n = READ;
        end
      end
      READ: begin
        MR   = 1'b1;
        Addr = lat_addr[BADDR_W-1:2];
        if (rd_last) state_n = lat_we ? WRITE : RESP;
      end
      WRITE: begin
        MW   = 1'b1;
        Addr = lat_addr[BADDR_W-1:2];
        WD   = (lat_size == SZ_WORD) ? lat_wdata : st_data;
        state_n = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rd_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_uns   <= req_unsigned;
        lat_size  <= req_size;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        rdata_q   <= '0;
        err_q     <= bad;
        cnt       <= '0;
      end
      if (state == READ) begin
        cnt <= cnt + 2'd1;
        if (rd_last) begin
          rd_q <= RD;
          if (!lat_we) rdata_q <= ld_data;
        end
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus a random
// request mix against a word-array reference memory.
module tb_mem_access_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        MR, MW;
  logic [7:0]  Addr;
  logic [31:0] WD;
  logic [31:0] RD;

  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  assign RD = dmem[Addr];

  mem_access_unit dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .MR           (MR),
    .MW           (MW),
    .Addr         (Addr),
    .WD           (WD),
    .RD           (RD)
  );

  function automatic logic [31:0] ld_ref(input logic [31:0] w,
      input logic [1:0] size, input logic [1:0] off, input logic uns);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = (w >> (16 * off[1])) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] st_ref(input logic [31:0] w,
      input logic [1:0] size, input logic [1:0] off, input logic [31:0] d);
    logic [31:0] mask;
    int sh;
    if (size == 2'd2) return d;
    sh   = (size == 2'd0) ? 8 * off : 16 * off[1];
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  function automatic logic bad_ref(input logic [1:0] size, input logic [9:0] a);
    return size == 2'd3 || (size == 2'd1 && a % 2 != 0) ||
           (size == 2'd2 && a % 4 != 0);
  endfunction

  task automatic do_req(
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [9:0]  addr,
    input  logic [31:0] wdata,
    input  int          hold,
    output logic [31:0] rdata,
    output logic        err,
    output int          nmr,
    output int          nmw,
    output logic [7:0]  mw_addr,
    output logic [31:0] mw_wd,
    output int          lat,
    output int          both,
    output int          unstable
  );
    nmr = 0; nmw = 0; lat = -1; both = 0; unstable = 0;
    mw_addr = '0; mw_wd = '0;
    @(negedge Clk);
    req_valid = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge Clk);
    @(posedge Clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (MR) nmr++;
      if (MW) begin
        nmw++; mw_addr = Addr; mw_wd = WD; dmem[Addr] = WD;
      end
      if (MR && MW) both++;
      if (rsp_valid) begin lat = i; break; end
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err ||
          req_ready !== 1'b0 || MR !== 1'b0 || MW !== 1'b0)
        unstable++;
    end
    rsp_ready = 1'b1;
    @(posedge Clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_chk++;
    if ({req_ready, rsp_valid, rsp_err, MR, MW} !== 5'b0)
      $display("FAIL reset_ctl got %b want 00000",
               {req_ready, rsp_valid, rsp_err, MR, MW});
    else n_pass++;
    n_chk++;
    if (rsp_rdata !== 32'h0 || WD !== 32'h0 || Addr !== 8'h0)
      $display("FAIL reset_data got rdata=%h wd=%h addr=%h want 0",
               rsp_rdata, WD, Addr);
    else n_pass++;
    Rst = 1'b0;
    @(negedge Clk);
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready);
    else n_pass++;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; logic [7:0] ma; logic [31:0] mw;
    int nr, nw, lt, bh, us;
    do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 0,
           rd, e, nr, nw, ma, mw, lt, bh, us);
    n_chk++;
    if (nw !== 1 || nr !== 0) $display("FAIL ws_pulses got mr=%0d mw=%0d want 0/1", nr, nw);
    else n_pass++;
    n_chk++;
    if (ma !== 8'd4 || mw !== 32'hDEADBEEF)
      $display("FAIL ws_bus got addr=%0d wd=%h want 4/deadbeef", ma, mw);
    else n_pass++;
    n_chk++;
    if (lt !== 2 || e !== 1'b0 || rd !== 32'h0)
      $display("FAIL ws_rsp got lat=%0d err=%b rdata=%h want 2/0/0", lt, e, rd);
    else n_pass++;
    do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0,
           rd, e, nr, nw, ma, mw, lt, bh, us);
    n_chk++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0)
      $display("FAIL wl_rsp got rdata=%h err=%b want deadbeef/0", rd, e);
    else n_pass++;
    n_chk++;
    if (lt !== 2 || nr !== 1 || nw !== 0)
      $display("FAIL wl_timing got lat=%0d mr=%0d mw=%0d want 2/1/0", lt, nr, nw);
    else n_pass++;
  endtask

  task automatic test_byte_rmw();
    logic [31:0] rd; logic e; logic [7:0] ma; logic [31:0] mw;
    int nr, nw, lt, bh, us;
    dmem[4] = 32'h11223344;
    do_req(1'b1, 2'd0, 1'b0, 10'h012, 32'h000000AB, 0,
           rd, e, nr, nw, ma, mw, lt, bh, us);
    n_chk++;
    if (nr !== 1 || nw !== 1 || lt !== 3)
      $display("FAIL rmw_seq got mr=%0d mw=%0d lat=%0d want 1/1/3", nr, nw, lt);
    else n_pass++;
    n_chk++;
    if (mw !== 32'h11AB3344 || ma !== 8'd4)
      $display("FAIL rmw_wd got wd=%h addr=%0d want 11ab3344/4", mw, ma);
    else n_pass++;
    do_req(1'b0, 2'd0, 1'b0, 10'h012, 32'h0, 0,
           rd, e, nr, nw, ma, mw, lt, bh, us);
    n_chk++;
    if (rd !== 32'hFFFFFFAB) $display("FAIL lb_signed got %h want ffffffab", rd);
    else n_pass++;
    do_req(1'b0, 2'd0, 1'b1, 10'h012, 32'h0, 0,
           rd, e, nr, nw, ma, mw, lt, bh, us);
    n_chk++;
    if (rd !== 32'h000000AB) $display("FAIL lb_unsigned got %h want 000000ab", rd);
    else n_pass++;
    do_req(1'b0, 2'd1, 1'b0, 10'h012, 32'h0, 0,
           rd, e, nr, nw, ma, mw, lt, bh, us);
    n_chk++;
    if (rd !== 32'h000011AB) $display("FAIL lh_signed got %h want 000011ab", rd);
    else n_pass++;
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic e; logic [7:0] ma; logic [31:0] mw;
    int nr, nw, lt, bh, us;
    logic        we_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  sz_t [3] = '{2'd2, 2'd1, 2'd3};
    logic [9:0]  ad_t [3] = '{10'h013, 10'h011, 10'h020};
    for (int k = 0; k < 3; k++) begin
      do_req(we_t[k], sz_t[k], 1'b0, ad_t[k], 32'h12345678, 0,
             rd, e, nr, nw, ma, mw, lt, bh, us);
      n_chk++;
      if (e !== 1'b1 || rd !== 32'h0 || nr !== 0 || nw !== 0 || lt !== 1)
        $display("FAIL misalign_%0d got err=%b rdata=%h mr=%0d mw=%0d lat=%0d want 1/0/0/0/1",
                 k, e, rd, nr, nw, lt);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic e; logic [7:0] ma; logic [31:0] mw;
    int nr, nw, lt, bh, us;
    dmem[9] = 32'h89ABCDEF;
    do_req(1'b0, 2'd1, 1'b0, 10'h026, 32'h0, 5,
           rd, e, nr, nw, ma, mw, lt, bh, us);
    n_chk++;
    if (us !== 0) $display("FAIL bp_stable got %0d unstable cycles want 0", us);
    else n_pass++;
    n_chk++;
    if (rd !== 32'hFFFF89AB) $display("FAIL bp_rdata got %h want ffff89ab", rd);
    else n_pass++;
  endtask

  task automatic test_reset_in_read();
    int mr_seen = 0;
    int act = 0;
    dmem[8] = 32'hCAFEF00D;
    @(negedge Clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1;
    req_unsigned = 1'b0; req_addr = 10'h022; req_wdata = 32'h00001234;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    @(negedge Clk);
    if (MR) mr_seen++;
    Rst = 1'b1;
    @(negedge Clk);
    if (MW) begin act++; dmem[Addr] = WD; end
    n_chk++;
    if (mr_seen !== 1) $display("FAIL rr_read got mr=%0d want 1", mr_seen);
    else n_pass++;
    n_chk++;
    if ({MR, MW, rsp_valid, req_ready} !== 4'b0)
      $display("FAIL rr_inreset got %b want 0000", {MR, MW, rsp_valid, req_ready});
    else n_pass++;
    Rst = 1'b0;
    @(negedge Clk);
    n_chk++;
    if (req_ready !== 1'b1) $display("FAIL rr_ready got %b want 1", req_ready);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (MW || MR || rsp_valid) act++;
      if (MW) dmem[Addr] = WD;
      @(negedge Clk);
    end
    n_chk++;
    if (act !== 0 || dmem[8] !== 32'hCAFEF00D)
      $display("FAIL rr_quiet got act=%0d mem=%h want 0/cafef00d", act, dmem[8]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd; logic e; logic [7:0] ma; logic [31:0] mw;
    int nr, nw, lt, bh, us;
    logic        we, uns, bad;
    logic [1:0]  sz;
    logic [9:0]  a;
    logic [31:0] d, exp_rd;
    int          r, exp_lat, both_tot;
    both_tot = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = dmem[i];
    for (int n = 0; n < 5000; n++) begin
      we  = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      r   = int'($urandom % 16);
      sz  = (r == 0) ? 2'd3 : 2'(r % 3);
      a   = 10'($urandom % 1024);
      if ($urandom % 3 != 0) begin
        if (sz == 2'd1) a = a & ~10'd1;
        if (sz == 2'd2) a = a & ~10'd3;
      end
      d   = $urandom;
      bad = bad_ref(sz, a);
      exp_rd = 32'h0;
      if (!bad && !we) exp_rd = ld_ref(ref_mem[a / 4], sz, 2'(a % 4), uns);
      if (!bad && we) ref_mem[a / 4] = st_ref(ref_mem[a / 4], sz, 2'(a % 4), d);
      exp_lat = bad ? 1 : (we && sz != 2'd2) ? 3 : 2;
      do_req(we, sz, uns, a, d, int'($urandom % 2),
             rd, e, nr, nw, ma, mw, lt, bh, us);
      both_tot += bh;
      n_chk++;
      if (rd !== exp_rd || e !== bad)
        $display("FAIL rand_rsp #%0d we=%b sz=%0d a=%h got %h/%b want %h/%b",
                 n, we, sz, a, rd, e, exp_rd, bad);
      else n_pass++;
      n_chk++;
      if (lt !== exp_lat || nw !== ((!bad && we) ? 1 : 0) ||
          nr !== ((bad || (we && sz == 2'd2)) ? 0 : 1))
        $display("FAIL rand_seq #%0d got lat=%0d mr=%0d mw=%0d want lat=%0d",
                 n, lt, nr, nw, exp_lat);
      else n_pass++;
    end
    n_chk++;
    if (both_tot !== 0) $display("FAIL rand_mr_mw got %0d overlaps want 0", both_tot);
    else n_pass++;
    for (int i = 0; i < 256; i++) begin
      n_chk++;
      if (dmem[i] !== ref_mem[i])
        $display("FAIL rand_mem[%0d] got %h want %h", i, dmem[i], ref_mem[i]);
      else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dmem[i] = $urandom;
    test_reset();
    test_word();
    test_byte_rmw();
    test_misalign();
    test_backpressure();
    test_reset_in_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
